// File: rtl/period_meter_pkg.sv
// Purpose : shared constants and FSM state type for the period meter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: default counter width, averaging depth, FSM state encoding.
package period_meter_pkg;

  localparam int CNT_W_DEF   = 24;
  // Number of periods summed per result in averaging builds.
  localparam int AVG_PERIODS = 4;
  localparam int AVG_SHIFT   = $clog2(AVG_PERIODS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/period_meter_edge_sync.sv
// Purpose : synchronise an async input and emit a one-cycle rising-edge pulse.
// Latency : rise asserts STAGES+1 clock cycles after the d transition.
// Backpressure: none; pulses are not stored.
// Ports   : clock, rst (async active-low), d (async input), rise (1-cycle pulse).
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic rst,
  input  logic d,
  output logic rise
);

  // pipe[STAGES-1:0] is the synchroniser, pipe[STAGES] the history bit.
  logic [STAGES:0] pipe;
  // fill tracks how far valid samples have propagated since reset, so a level
  // that is already high at release is not mistaken for a rising edge.
  logic [STAGES:0] fill;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      pipe <= '0;
      fill <= '0;
      rise <= 1'b0;
    end else begin
      pipe <= {pipe[STAGES-1:0], d};
      fill <= {fill[STAGES-1:0], 1'b1};
      rise <= fill[STAGES] & pipe[STAGES-1] & ~pipe[STAGES];
    end
  end

endmodule

// File: rtl/period_meter.sv
// Purpose : measure clock cycles between consecutive rising edges of sig_in.
// Latency : result written the cycle the closing edge pulse is seen (SYNC_STAGES+1 after the pin edge).
// Backpressure: valid/period/timeout held until ack; start ignored while busy or holding a result.
// Ports   : clock, rst (async active-low), sig_in (async), start, ack ->
//           busy, valid, period[CNT_W-1:0], timeout (qualified by valid).
// Config  : define PERIOD_METER_AVG_EN to average over AVG_PERIODS consecutive periods.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2            // must be >= 2
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] period,
  output logic             timeout
);

  state_t state;
  logic   rise;

  edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clock (clock),
    .rst   (rst),
    .d     (sig_in),
    .rise  (rise)
  );

`ifdef PERIOD_METER_AVG_EN
  localparam int              ACC_W    = CNT_W + AVG_SHIFT;
  localparam logic [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [ACC_W-1:0] ACC_NEAR = ACC_MAX - ACC_ONE;
  localparam logic [AVG_SHIFT-1:0] LAST_PER = AVG_SHIFT'(AVG_PERIODS - 1);

  // acc keeps counting straight through intermediate edges, so on the final
  // edge it holds the sum of all AVG_PERIODS periods.
  logic [ACC_W-1:0]     acc;
  logic [AVG_SHIFT-1:0] n_per;   // edges seen inside MEASURE
`else
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - CNT_ONE;

  logic [CNT_W-1:0] cnt;
`endif

  assign busy = (state == ST_ARMED) || (state == ST_MEASURE);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      valid   <= 1'b0;
      period  <= '0;
      timeout <= 1'b0;
`ifdef PERIOD_METER_AVG_EN
      acc     <= '0;
      n_per   <= '0;
`else
      cnt     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_ARMED;
        end

        // The arming edge opens the window; it counts as cycle 1 of the period.
        ST_ARMED: begin
          if (rise) begin
            state <= ST_MEASURE;
`ifdef PERIOD_METER_AVG_EN
            acc   <= ACC_ONE;
            n_per <= '0;
`else
            cnt   <= CNT_ONE;
`endif
          end
        end

        ST_MEASURE: begin
`ifdef PERIOD_METER_AVG_EN
          if (rise && (n_per == LAST_PER)) begin
            period  <= acc[ACC_W-1:AVG_SHIFT];
            timeout <= 1'b0;
            valid   <= 1'b1;
            state   <= ST_DONE;
          end else if (acc == ACC_NEAR) begin
            // Saturate instead of wrapping; report all ones.
            acc     <= ACC_MAX;
            period  <= '1;
            timeout <= 1'b1;
            valid   <= 1'b1;
            state   <= ST_DONE;
          end else begin
            acc <= acc + ACC_ONE;
            if (rise) n_per <= n_per + AVG_SHIFT'(1);
          end
`else
          if (rise) begin
            period  <= cnt;
            timeout <= 1'b0;
            valid   <= 1'b1;
            state   <= ST_DONE;
          end else if (cnt == CNT_NEAR) begin
            // Saturate instead of wrapping; report all ones.
            cnt     <= CNT_MAX;
            period  <= CNT_MAX;
            timeout <= 1'b1;
            valid   <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
`endif
        end

        // A start arriving together with ack re-arms without passing IDLE.
        ST_DONE: begin
          if (ack) begin
            valid <= 1'b0;
            state <= start ? ST_ARMED : ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter CNT_W, default 24, width of the period counter and result.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on sig_in (minimum 2).
REQ-003 clock  input  1  sole clock; all state on posedge clock.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 sig_in  input  1  asynchronous signal to measure, e.g. a divided clock.
REQ-006 start  input  1  single-cycle request to begin one measurement.
REQ-007 ack  input  1  consumer acknowledges the result; clears valid.
REQ-008 busy  output  1  high in ARMED and MEASURE.
REQ-009 valid  output  1  result available; held until ack.
REQ-010 period  output  CNT_W  clock cycles between consecutive sig_in rising edges.
REQ-011 timeout  output  1  measurement ended by counter saturation; qualified by valid.

Function
REQ-012 sig_in SHALL pass SYNC_STAGES flip-flops and then a rising-edge detector producing a one-cycle edge pulse, SYNC_STAGES+1 cycles after the sig_in transition.
REQ-013 FSM states SHALL be IDLE, ARMED, MEASURE, DONE.
REQ-014 IDLE: start=1 -> ARMED; otherwise stay.
REQ-015 ARMED: edge -> MEASURE with cnt=1; otherwise stay; never times out.
REQ-016 MEASURE: no edge -> cnt+1; edge -> period<=cnt, timeout<=0, valid<=1, DONE.
REQ-017 MEASURE: cnt reaching 2^CNT_W-1 without edge -> period<=all ones, timeout<=1, valid<=1, DONE; cnt never wraps.
REQ-018 For a stable sig_in of period P clocks (P>=4, high and low >=2 clocks each), period SHALL equal P exactly.
REQ-019 DONE: ack=1 -> valid<=0 next cycle, IDLE; ack and start in the same cycle -> valid<=0, ARMED.
REQ-020 start SHALL be ignored in ARMED, MEASURE, and DONE without ack; ack outside DONE is ignored.
REQ-021 period and timeout SHALL hold their last values until the next result is written.
REQ-022 Arithmetic SHALL be unsigned, CNT_W bits; no implicit truncation of cnt.

Reset
REQ-023 rst=0 SHALL immediately force IDLE, cnt=0, period=0, valid=0, timeout=0, busy=0, synchronizer and edge-detector flops=0.
REQ-024 Reset mid-measurement SHALL discard the partial count; no valid pulse after release.
REQ-025 A sig_in already high at reset release SHALL NOT produce an edge.

Configuration
REQ-026 Macro PERIOD_METER_AVG_EN: when defined, MEASURE SHALL span 4 consecutive periods, accumulating in CNT_W+2 bits, and period SHALL be sum>>2 (truncated); saturation of the accumulator SHALL set timeout.
REQ-027 Without PERIOD_METER_AVG_EN, a single period is measured per REQ-016; no accumulator or period counter logic is present.

Structure
REQ-028 Shared package period_meter_pkg SHALL hold the FSM state enum, default CNT_W, and the AVG_PERIODS=4 constant.
REQ-029 Sub-module edge_sync SHALL implement synchronizer plus rising-edge detector (ports clock, rst, d, rise); period_meter instantiates it once.

Verification
REQ-030 sig_in square wave period 10 clocks, start pulse -> valid=1, period=10, timeout=0; ack -> valid=0 next cycle.
REQ-031 CNT_W=8, sig_in one edge then held high, start -> valid with period=255, timeout=1.
REQ-032 start pulses during MEASURE and in DONE without ack -> no restart, result unchanged; ack+start same cycle -> ARMED, busy=1.
REQ-033 rst=0 for 1 cycle mid-MEASURE on period-50 wave -> all outputs 0 at once, state IDLE, no valid until next start.
REQ-034 PERIOD_METER_AVG_EN, periods 10,12,10,13 -> period=11, timeout=0.
REQ-035 sig_in high at reset release, period-20 wave, start -> first measured period=20 (no spurious edge).
